// File: rtl/lsu_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_unit_if
// Purpose  : Bundles the three LSU-facing channels into one interface.
//            - EXU issue channel:  exu_lsu_valid/ready, addr, data, info, dst
//            - Memory bus channel: lsu_mem_req/we/addr/wdata/wstrb,
//                                  mem_lsu_gnt/rvalid/rdata
//            - WBU result channel: lsu_wbu_valid/ready/data/dst, lsu_misalign
// Modports : master - the LSU side (drives ready, bus request, result)
//            slave  - the environment side (EXU, memory, WBU)
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_unit_if;
  // EXU -> LSU issue channel
  logic        exu_lsu_valid;
  logic        exu_lsu_ready;
  logic [63:0] exu_lsu_addr;
  logic [63:0] exu_lsu_data;
  logic [3:0]  exu_lsu_info;
  logic [4:0]  exu_lsu_dst;
  // LSU <-> memory bus
  logic        lsu_mem_req;
  logic        lsu_mem_we;
  logic [63:0] lsu_mem_addr;
  logic [63:0] lsu_mem_wdata;
  logic [7:0]  lsu_mem_wstrb;
  logic        mem_lsu_gnt;
  logic        mem_lsu_rvalid;
  logic [63:0] mem_lsu_rdata;
  // LSU -> WBU result channel
  logic        lsu_wbu_valid;
  logic        lsu_wbu_ready;
  logic [63:0] lsu_wbu_data;
  logic [4:0]  lsu_wbu_dst;
  logic        lsu_misalign;

  modport master (
    input  exu_lsu_valid, exu_lsu_addr, exu_lsu_data, exu_lsu_info, exu_lsu_dst,
    output exu_lsu_ready,
    output lsu_mem_req, lsu_mem_we, lsu_mem_addr, lsu_mem_wdata, lsu_mem_wstrb,
    input  mem_lsu_gnt, mem_lsu_rvalid, mem_lsu_rdata,
    output lsu_wbu_valid, lsu_wbu_data, lsu_wbu_dst, lsu_misalign,
    input  lsu_wbu_ready
  );

  modport slave (
    output exu_lsu_valid, exu_lsu_addr, exu_lsu_data, exu_lsu_info, exu_lsu_dst,
    input  exu_lsu_ready,
    input  lsu_mem_req, lsu_mem_we, lsu_mem_addr, lsu_mem_wdata, lsu_mem_wstrb,
    output mem_lsu_gnt, mem_lsu_rvalid, mem_lsu_rdata,
    input  lsu_wbu_valid, lsu_wbu_data, lsu_wbu_dst, lsu_misalign,
    output lsu_wbu_ready
  );
endinterface
`default_nettype wire

// File: rtl/lsu_unit.sv
`default_nettype none
// ============================================================================
// Module   : lsu_unit
// Purpose  : Single-outstanding load/store unit. Accepts one memory op from
//            the EXU, issues a doubleword-aligned bus request with byte
//            strobes, waits for the response, aligns/extends load data and
//            hands the result to the WBU.
// Ports    : core_clk - sole clock, rising edge
//            core_rst - synchronous reset, active low
//            bus      - lsu_unit_if.master (EXU issue, memory bus, WBU result)
// Config   : LSU_MISALIGN_CHECK_EN - when defined, accesses not aligned to
//            their size skip the bus and complete with lsu_misalign=1.
//            When undefined, no check is made and strobes beyond lane 7 are
//            simply dropped.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_unit (
  input  logic       core_clk,
  input  logic       core_rst,
  lsu_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [63:0] r_addr;
  logic [63:0] r_data;
  logic [3:0]  r_info;
  logic [4:0]  r_dst;
  logic [63:0] r_rdata;
  logic        r_misalign;

  logic        w_accept;
  logic        w_in_misalign;
  logic        w_capture;
  logic [1:0]  w_size;
  logic        w_is_store;
  logic        w_sign_ext;
  logic [7:0]  w_mask;
  logic [7:0]  w_strb;
  logic [63:0] w_wdata;
  logic [63:0] w_shift;
  logic [63:0] w_load;

  assign w_accept   = (r_state == S_IDLE) && bus.exu_lsu_valid;
  assign w_size     = r_info[2:1];
  assign w_is_store = r_info[0];
  assign w_sign_ext = ~r_info[3];

  // Alignment of the incoming op is judged at accept time so the FSM can
  // bypass the bus entirely.
`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    w_in_misalign = 1'b0;
    case (bus.exu_lsu_info[2:1])
      2'b00:   w_in_misalign = 1'b0;
      2'b01:   w_in_misalign = bus.exu_lsu_addr[0];
      2'b10:   w_in_misalign = |bus.exu_lsu_addr[1:0];
      default: w_in_misalign = |bus.exu_lsu_addr[2:0];
    endcase
  end
`else
  assign w_in_misalign = 1'b0;
`endif

  // Read data is only taken while a bus transaction is actually pending;
  // responses seen in IDLE/RESP (e.g. for an op abandoned by reset) are dropped.
  assign w_capture = bus.mem_lsu_rvalid &&
                     (((r_state == S_REQ) && bus.mem_lsu_gnt) || (r_state == S_WAIT));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.exu_lsu_valid) w_next = w_in_misalign ? S_RESP : S_REQ;
      S_REQ:  if (bus.mem_lsu_gnt)   w_next = bus.mem_lsu_rvalid ? S_RESP : S_WAIT;
      S_WAIT: if (bus.mem_lsu_rvalid) w_next = S_RESP;
      S_RESP: if (bus.lsu_wbu_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (!core_rst) begin
      r_state    <= S_IDLE;
      r_addr     <= 64'd0;
      r_data     <= 64'd0;
      r_info     <= 4'd0;
      r_dst      <= 5'd0;
      r_rdata    <= 64'd0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr     <= bus.exu_lsu_addr;
        r_data     <= bus.exu_lsu_data;
        r_info     <= bus.exu_lsu_info;
        r_dst      <= bus.exu_lsu_dst;
        r_misalign <= w_in_misalign;
      end
      if (w_capture) r_rdata <= bus.mem_lsu_rdata;
    end
  end

  // Byte lanes: the 8-bit shift drops any strobe that would fall past lane 7.
  always_comb begin
    w_mask  = 8'hFF;
    w_wdata = r_data;
    case (w_size)
      2'b00:   begin w_mask = 8'h01; w_wdata = {8{r_data[7:0]}};  end
      2'b01:   begin w_mask = 8'h03; w_wdata = {4{r_data[15:0]}}; end
      2'b10:   begin w_mask = 8'h0F; w_wdata = {2{r_data[31:0]}}; end
      default: begin w_mask = 8'hFF; w_wdata = r_data;            end
    endcase
  end
  assign w_strb = w_mask << r_addr[2:0];

  // Load alignment: bring the addressed byte down to lane 0, then extend.
  assign w_shift = r_rdata >> {r_addr[2:0], 3'b000};
  always_comb begin
    w_load = w_shift;
    case (w_size)
      2'b00:   w_load = {{56{w_sign_ext & w_shift[7]}},  w_shift[7:0]};
      2'b01:   w_load = {{48{w_sign_ext & w_shift[15]}}, w_shift[15:0]};
      2'b10:   w_load = {{32{w_sign_ext & w_shift[31]}}, w_shift[31:0]};
      default: w_load = w_shift;
    endcase
  end

  // Outputs are gated by state so everything idles at zero outside its phase.
  always_comb begin
    bus.exu_lsu_ready = (r_state == S_IDLE);
    bus.lsu_mem_req   = 1'b0;
    bus.lsu_mem_we    = 1'b0;
    bus.lsu_mem_addr  = 64'd0;
    bus.lsu_mem_wdata = 64'd0;
    bus.lsu_mem_wstrb = 8'd0;
    bus.lsu_wbu_valid = 1'b0;
    bus.lsu_wbu_data  = 64'd0;
    bus.lsu_wbu_dst   = 5'd0;
    bus.lsu_misalign  = 1'b0;
    if (r_state == S_REQ) begin
      bus.lsu_mem_req   = 1'b1;
      bus.lsu_mem_we    = w_is_store;
      bus.lsu_mem_addr  = {r_addr[63:3], 3'b000};
      bus.lsu_mem_wdata = w_wdata;
      bus.lsu_mem_wstrb = w_strb;
    end
    if (r_state == S_RESP) begin
      bus.lsu_wbu_valid = 1'b1;
      bus.lsu_misalign  = r_misalign;
      if (!w_is_store && !r_misalign) begin
        bus.lsu_wbu_data = w_load;
        bus.lsu_wbu_dst  = r_dst;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/lsu_unit.md
LSU_UNIT -- requirements
Module: lsu_unit

Interface
REQ-001 SHALL have ports: core_clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: core_rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: exu_lsu_valid  in  1  EXU presents a memory op this cycle.
REQ-004 SHALL have ports: exu_lsu_ready  out  1  unit can accept an op.
REQ-005 SHALL have ports: exu_lsu_addr  in  64  effective byte address from EXU.
REQ-006 SHALL have ports: exu_lsu_data  in  64  store data (rs2), lowest bytes significant.
REQ-007 SHALL have ports: exu_lsu_info  in  4  [0] store, [2:1] size (00 B, 01 H, 10 W, 11 D), [3] unsigned load.
REQ-008 SHALL have ports: exu_lsu_dst  in  5  load destination register.
REQ-009 SHALL have ports: lsu_mem_req/lsu_mem_we  out  1/1  bus request, write enable.
REQ-010 SHALL have ports: lsu_mem_addr  out  64  address with [2:0]=0.
REQ-011 SHALL have ports: lsu_mem_wdata/lsu_mem_wstrb  out  64/8  lane-placed data, byte strobes.
REQ-012 SHALL have ports: mem_lsu_gnt  in  1  request accepted; mem_lsu_rvalid  in  1  response (read data or write ack); mem_lsu_rdata  in  64.
REQ-013 SHALL have ports: lsu_wbu_valid  out  1; lsu_wbu_ready  in  1; lsu_wbu_data  out  64; lsu_wbu_dst  out  5; lsu_misalign  out  1.

Function
REQ-014 SHALL implement FSM IDLE, REQ, WAIT, RESP; exu_lsu_ready = (state==IDLE).
REQ-015 SHALL, in IDLE with exu_lsu_valid=1, register addr, data, info, dst and enter REQ next cycle.
REQ-016 SHALL hold lsu_mem_req=1 and all lsu_mem_* stable in REQ until mem_lsu_gnt=1.
REQ-017 SHALL go REQ->WAIT on gnt without rvalid; REQ->RESP on gnt with rvalid in the same cycle.
REQ-018 SHALL go WAIT->RESP on mem_lsu_rvalid=1, capturing mem_lsu_rdata.
REQ-019 SHALL drive lsu_wbu_valid=1 only in RESP, holding data/dst stable until lsu_wbu_ready=1, then return to IDLE.
REQ-020 SHALL ignore mem_lsu_rvalid in IDLE and RESP.
REQ-021 SHALL drive wstrb = size mask (0x01/0x03/0x0F/0xFF) shifted left by addr[2:0]; wdata = low size bytes of exu_lsu_data replicated across all lanes.
REQ-022 SHALL form the load result as rdata >> (8*addr[2:0]), truncated to size, then zero-extended if info[3]=1, else sign-extended, to 64 bits.
REQ-023 SHALL, for stores, drive lsu_wbu_data=0 and lsu_wbu_dst=0 in RESP.
REQ-024 SHALL give minimum latency accept->lsu_wbu_valid of 2 cycles (gnt and rvalid both in first REQ cycle).
REQ-025 SHALL, in IDLE, drive lsu_mem_req=0, lsu_wbu_valid=0 and lsu_misalign=0.

Reset
REQ-026 SHALL, on core_rst=0 at a clock edge, enter IDLE from any state, abandoning any in-flight op.
REQ-027 SHALL reset all outputs to 0 except exu_lsu_ready, which is 1 from the first cycle after reset.
REQ-028 SHALL ignore any response arriving after reset for an abandoned op.

Configuration
REQ-029 SHALL, with LSU_MISALIGN_CHECK_EN defined, treat an access with addr not aligned to size as misaligned: no bus request, REQ skipped, go to RESP with lsu_misalign=1, lsu_wbu_data=0, lsu_wbu_dst=0.
REQ-030 SHALL, without LSU_MISALIGN_CHECK_EN, not check alignment: lsu_misalign tied 0, strobes crossing lane 7 truncated, and the access proceeds normally.

Verification
REQ-031 SHALL cover: LB at 0x1003, rdata 0x0000_0000_8000_0000 (byte 3 = 0x80) -> lsu_mem_addr 0x1000, lsu_wbu_data 0xFFFF_FFFF_FFFF_FF80.
REQ-032 SHALL cover: SH at 0x2006, data 0xABCD -> wstrb 0xC0, wdata 0xABCD_ABCD_ABCD_ABCD, we=1; on ack lsu_wbu_valid=1 with data 0.
REQ-033 SHALL cover: gnt held low 3 cycles -> req and address stable 3 cycles; gnt+rvalid together -> RESP next cycle.
REQ-034 SHALL cover: lsu_wbu_ready low 4 cycles in RESP -> valid/data held, exu_lsu_ready=0 throughout.
REQ-035 SHALL cover: core_rst=0 in WAIT, then late rvalid -> IDLE, no lsu_wbu_valid.
REQ-036 SHALL cover: LW at 0x3002 with LSU_MISALIGN_CHECK_EN -> no lsu_mem_req, lsu_misalign=1; without the macro -> bus access proceeds.
